bcnn_fmap_collector: RTL and testbench

BCNN_FMAP_COLLECTOR -- requirements
Module: bcnn_fmap_collector

---
 rtl/bcnn_fmap_collector_pkg.sv | 16 +
 rtl/bcnn_fmap_collector_row_packer.sv | 35 +++
 rtl/bcnn_fmap_collector.sv | 86 ++++++++
 tb/tb_bcnn_fmap_collector.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bcnn_fmap_collector_pkg.sv
// Shared BCNN feature-map geometry and collector FSM encoding.
// Output geometry follows from a valid (no padding) KERNEL_SIZE convolution.
package bcnn_fmap_collector_pkg;

    localparam int IMG_WIDTH   = 28;
    localparam int IMG_HEIGHT  = 28;
    localparam int KERNEL_SIZE = 3;
    localparam int OUT_COLS    = IMG_WIDTH - KERNEL_SIZE + 1;
    localparam int OUT_ROWS    = IMG_HEIGHT - KERNEL_SIZE + 1;

    typedef enum logic {
        ST_CAPTURE = 1'b0,
        ST_READ    = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/bcnn_fmap_collector_row_packer.sv
// Serial-to-parallel row packer: one binarized pixel per accepted sample.
// row_word already includes the incoming bit so a full row can be committed on the same edge.
module bcnn_row_packer #(
    parameter int WIDTH = 26,
    localparam int COL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             bin,
    output logic [WIDTH-1:0] row_word,
    output logic             row_full
);

    logic [WIDTH-1:0] data_q;
    logic [COL_W-1:0] col_q;

    always_comb begin
        row_word        = data_q;
        row_word[col_q] = bin;
    end

    assign row_full = shift_en && (col_q == COL_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            col_q  <= '0;
        end else if (shift_en) begin
            data_q <= row_word;
            col_q  <= row_full ? '0 : col_q + COL_W'(1);
        end
    end

endmodule

// File: rtl/bcnn_fmap_collector.sv
// Collects one binarized feature-map frame into row memory, then drains it
// row by row over a valid/ready port before capturing the next frame.
module bcnn_fmap_collector
    import bcnn_fmap_collector_pkg::*;
#(
    parameter int IMG_WIDTH   = bcnn_fmap_collector_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT  = bcnn_fmap_collector_pkg::IMG_HEIGHT,
    parameter int KERNEL_SIZE = bcnn_fmap_collector_pkg::KERNEL_SIZE,
    localparam int OUT_COLS   = IMG_WIDTH - KERNEL_SIZE + 1,
    localparam int OUT_ROWS   = IMG_HEIGHT - KERNEL_SIZE + 1,
    localparam int ROW_W      = $clog2(OUT_ROWS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bin_in,
    input  logic                bin_valid,
    input  logic                rd_ready,
    output logic                rd_valid,
    output logic [OUT_COLS-1:0] rd_data,
    output logic [ROW_W-1:0]    rd_row,
    output logic                frame_done,
    output logic                busy,
    output logic                overflow_err
);

    fsm_state_t          state, next_state;
    logic [ROW_W-1:0]    row_cnt, rd_ptr;
    logic [OUT_COLS-1:0] mem [OUT_ROWS];
    logic [OUT_COLS-1:0] row_word;
    logic                accept, row_full, handshake;
    logic                last_row, last_rd;
    logic                frame_done_q, overflow_q;

    assign accept    = (state == ST_CAPTURE) && bin_valid;
    assign handshake = (state == ST_READ) && rd_ready;
    assign last_row  = (row_cnt == ROW_W'(OUT_ROWS - 1));
    assign last_rd   = (rd_ptr == ROW_W'(OUT_ROWS - 1));

    bcnn_row_packer #(.WIDTH(OUT_COLS)) u_packer (
        .clk      (clk),
        .reset    (reset),
        .shift_en (accept),
        .bin      (bin_in),
        .row_word (row_word),
        .row_full (row_full)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_CAPTURE: if (row_full && last_row) next_state = ST_READ;
            ST_READ:    if (handshake && last_rd) next_state = ST_CAPTURE;
            default:    next_state = ST_CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_CAPTURE;
            row_cnt      <= '0;
            rd_ptr       <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state        <= next_state;
            frame_done_q <= (state == ST_CAPTURE) && (next_state == ST_READ);
            if (row_full) row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
            if (handshake) rd_ptr <= last_rd ? '0 : rd_ptr + ROW_W'(1);
            // Samples arriving while draining are dropped, but never silently.
            if ((state == ST_READ) && bin_valid) overflow_q <= 1'b1;
        end
    end

    // Frame memory is deliberately not reset; every row is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (row_full) mem[row_cnt] <= row_word;
    end

    assign busy         = (state == ST_READ);
    assign rd_valid     = busy;
    assign rd_row       = busy ? rd_ptr : '0;
    assign rd_data      = busy ? mem[rd_ptr] : '0;
    assign frame_done   = frame_done_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_bcnn_fmap_collector.sv
// Directed bench for bcnn_fmap_collector: frames are streamed in, expected row
// words are queued from a pixel model and popped against each read handshake.
module tb_bcnn_fmap_collector;

    localparam int OUT_COLS = 26;
    localparam int OUT_ROWS = 26;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                bin_in = 1'b0;
    logic                bin_valid = 1'b0;
    logic                rd_ready = 1'b0;
    logic                rd_valid;
    logic [OUT_COLS-1:0] rd_data;
    logic [4:0]          rd_row;
    logic                frame_done;
    logic                busy;
    logic                overflow_err;

    logic [OUT_COLS-1:0] exp_q[$];
    bit                  rand_img [OUT_ROWS][OUT_COLS];
    int                  checks = 0;
    int                  failures = 0;
    int                  cyc = 0;

    bcnn_fmap_collector dut (
        .clk          (clk),
        .reset        (reset),
        .bin_in       (bin_in),
        .bin_valid    (bin_valid),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_row       (rd_row),
        .frame_done   (frame_done),
        .busy         (busy),
        .overflow_err (overflow_err)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pixel model: 0 all ones, 1 checkerboard, 2 single pixel at (25,25), 3 random image
    function automatic logic pix(input int pat, input int r, input int c);
        case (pat)
            0:       return 1'b1;
            1:       return 1'((r + c) & 1);
            2:       return (r == 25) && (c == 25);
            default: return rand_img[r][c];
        endcase
    endfunction

    task automatic push_frame(input int pat);
        logic [OUT_COLS-1:0] w;
        for (int r = 0; r < OUT_ROWS; r++) begin
            for (int c = 0; c < OUT_COLS; c++) w[c] = pix(pat, r, c);
            exp_q.push_back(w);
        end
    endtask

    // Drives a full frame; gap inserts an idle bin_valid=0 cycle after every sample.
    task automatic stream_frame(input int pat, input bit gap, input int exp_latency);
        int t0 = 0;
        push_frame(pat);
        for (int r = 0; r < OUT_ROWS; r++) begin
            for (int c = 0; c < OUT_COLS; c++) begin
                @(negedge clk);
                if (r == 0 && c == 0) t0 = cyc;
                if (r == OUT_ROWS - 1 && c == OUT_COLS - 1) begin
                    check("busy_during_capture", 32'(busy), 32'd0);
                    check("done_before_last", 32'(frame_done), 32'd0);
                end
                bin_valid = 1'b1;
                bin_in    = pix(pat, r, c);
                if (gap) begin
                    @(negedge clk);
                    bin_valid = 1'b0;
                end
            end
        end
        if (!gap) begin
            @(negedge clk);
            bin_valid = 1'b0;
        end
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("frame_done_latency", 32'(cyc - t0), 32'(exp_latency));
        check("busy_in_read", 32'(busy), 32'd1);
    endtask

    // Stalls for 'stall' cycles, then drains with rd_ready held high.
    task automatic drain(input int stall);
        logic [OUT_COLS-1:0] exp;
        int n = 0;
        int guard = 0;
        rd_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(rd_valid), 32'd1);
            check("stall_row", 32'(rd_row), 32'd0);
            check("stall_data", 32'(rd_data), 32'(exp_q[0]));
            check("done_one_cycle", 32'(frame_done), 32'd0);
        end
        rd_ready = 1'b1;
        while (n < OUT_ROWS && guard < 200) begin
            if (rd_valid && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check($sformatf("rd_data_row%0d", n), 32'(rd_data), 32'(exp));
                check($sformatf("rd_row_%0d", n), 32'(rd_row), 32'(n));
                n++;
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("drain_timeout", 32'(n), 32'(OUT_ROWS));
        rd_ready = 1'b0;
        check("busy_after_drain", 32'(busy), 32'd0);
        check("valid_after_drain", 32'(rd_valid), 32'd0);
        check("data_muxed_zero", 32'(rd_data), 32'd0);
    endtask

    initial begin
        for (int r = 0; r < OUT_ROWS; r++)
            for (int c = 0; c < OUT_COLS; c++)
                rand_img[r][c] = 1'($urandom_range(0, 1));

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow_err), 32'd0);
        check("rst_rd_row", 32'(rd_row), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;

        // All ones, continuous streaming
        stream_frame(0, 1'b0, 676);
        drain(0);

        // Checkerboard with a 5-cycle read stall
        stream_frame(1, 1'b0, 676);
        drain(5);

        // All ones with bin_valid toggling, then samples during READ
        stream_frame(0, 1'b1, 1351);
        bin_valid = 1'b1;
        bin_in    = 1'b0;
        repeat (3) @(negedge clk);
        bin_valid = 1'b0;
        check("overflow_set", 32'(overflow_err), 32'd1);
        check("overflow_row_held", 32'(rd_row), 32'd0);
        check("overflow_data_held", 32'(rd_data), 32'(exp_q[0]));
        drain(0);

        // Next frame still captures correctly; overflow stays sticky
        stream_frame(3, 1'b0, 676);
        check("overflow_sticky", 32'(overflow_err), 32'd1);
        drain(0);
        check("overflow_sticky_after", 32'(overflow_err), 32'd1);

        // Partial frame discarded by reset
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            bin_valid = 1'b1;
            bin_in    = 1'b1;
        end
        @(negedge clk);
        bin_valid = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_overflow", 32'(overflow_err), 32'd0);
        reset = 1'b0;
        stream_frame(2, 1'b0, 676);
        drain(0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
